rx_lbuf_sel: RTL and testbench

RX_LBUF_SEL -- requirements
Module: rx_lbuf_sel

---
 rtl/rx_lbuf_sel_if.sv | 35 +++
 rtl/rx_lbuf_sel.sv | 148 ++++++++++++++
 tb/tb_rx_lbuf_sel.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_lbuf_sel_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : rx_lbuf_sel_if
// Desc   : Host lbuf grant/return and writer advance/close signals.
// Rev    : 1.0 - initial release
// ============================================================================
interface rx_lbuf_sel_if;
    logic [63:0] lbuf1_addr;
    logic [63:0] lbuf2_addr;
    logic        lbuf1_en;
    logic        lbuf2_en;
    logic        lbuf1_dn;
    logic        lbuf2_dn;
    logic [63:0] wr_addr;
    logic        wr_vld;
    logic        wr_id;
    logic [15:0] wr_room;
    logic        adv_vld;
    logic [8:0]  adv_qw;
    logic        close;

    modport master (
        input  lbuf1_addr, lbuf2_addr, lbuf1_en, lbuf2_en,
        input  adv_vld, adv_qw, close,
        output lbuf1_dn, lbuf2_dn, wr_addr, wr_vld, wr_id, wr_room
    );

    modport slave (
        output lbuf1_addr, lbuf2_addr, lbuf1_en, lbuf2_en,
        output adv_vld, adv_qw, close,
        input  lbuf1_dn, lbuf2_dn, wr_addr, wr_vld, wr_id, wr_room
    );
endinterface
`default_nettype wire

// File: rtl/rx_lbuf_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : rx_lbuf_sel
// Desc   : Alternates between two host lbufs, tracks the write offset and
//          returns each buffer on close/full (idle timeout: RX_LBUF_TIMEOUT_EN).
// Rev    : 1.0 - initial release
// ============================================================================
module rx_lbuf_sel #(
    parameter int LBUF_QW     = 16384,
    parameter int TIMEOUT_CYC = 65535
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rx_lbuf_sel_if.master bus
);

    typedef enum logic [1:0] {
        WAIT1 = 2'd0,
        ACT1  = 2'd1,
        WAIT2 = 2'd2,
        ACT2  = 2'd3
    } state_t;

    localparam logic [16:0] c_QW = 17'(LBUF_QW);

    if (LBUF_QW < 256 || LBUF_QW > 32768 || (LBUF_QW & (LBUF_QW - 1)) != 0 ||
        TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("rx_lbuf_sel: LBUF_QW or TIMEOUT_CYC out of range");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_base;
    logic [16:0] r_offset;
    logic        r_arm1;
    logic        r_arm2;
    logic        r_dn1;
    logic        r_dn2;

    logic        w_act;
    logic        w_adv;
    logic        w_open1;
    logic        w_open2;
    logic [16:0] w_sum;
    logic [16:0] w_off_adv;
    logic        w_full;
    logic        w_tmo;
    logic        w_done;

    assign w_act     = (r_state == ACT1) || (r_state == ACT2);
    assign w_adv     = w_act && bus.adv_vld;
    assign w_open1   = (r_state == WAIT1) && bus.lbuf1_en && r_arm1;
    assign w_open2   = (r_state == WAIT2) && bus.lbuf2_en && r_arm2;
    assign w_sum     = r_offset + {8'd0, bus.adv_qw};
    assign w_off_adv = (w_sum >= c_QW) ? c_QW : w_sum;
    assign w_full    = (r_offset == c_QW) || (w_adv && (w_sum >= c_QW));
    // The advance is always folded into the offset before closing, so a
    // combined adv+close returns the buffer with the advanced offset.
    assign w_done    = w_act && (bus.close || w_full || w_tmo);

`ifdef RX_LBUF_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

    logic [c_TW-1:0] r_idle;
    logic            w_idle;

    assign w_idle = w_act && (r_offset != 17'd0) && !bus.adv_vld;
    assign w_tmo  = w_idle && (r_idle == c_TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (!w_idle || w_done) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT1:   if (w_open1) w_state_nxt = ACT1;
            ACT1:    if (w_done)  w_state_nxt = WAIT2;
            WAIT2:   if (w_open2) w_state_nxt = ACT2;
            ACT2:    if (w_done)  w_state_nxt = WAIT1;
            default: w_state_nxt = WAIT1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= 64'd0;
            r_offset <= 17'd0;
            r_arm1   <= 1'b1;
            r_arm2   <= 1'b1;
            r_dn1    <= 1'b0;
            r_dn2    <= 1'b0;
        end else begin
            r_dn1 <= (r_state == ACT1) && w_done;
            r_dn2 <= (r_state == ACT2) && w_done;

            if (w_open1) begin
                r_base   <= bus.lbuf1_addr;
                r_offset <= 17'd0;
            end else if (w_open2) begin
                r_base   <= bus.lbuf2_addr;
                r_offset <= 17'd0;
            end else if (w_adv) begin
                r_offset <= w_off_adv;
            end

            // A buffer re-arms only after its en has been seen low once.
            if ((r_state == ACT1) && w_done) begin
                r_arm1 <= 1'b0;
            end else if (!bus.lbuf1_en) begin
                r_arm1 <= 1'b1;
            end

            if ((r_state == ACT2) && w_done) begin
                r_arm2 <= 1'b0;
            end else if (!bus.lbuf2_en) begin
                r_arm2 <= 1'b1;
            end
        end
    end

    assign bus.wr_vld   = w_act;
    assign bus.wr_id    = (r_state == ACT2);
    assign bus.wr_addr  = r_base + {44'd0, r_offset, 3'd0};
    assign bus.wr_room  = 16'(c_QW - r_offset);
    assign bus.lbuf1_dn = r_dn1;
    assign bus.lbuf2_dn = r_dn2;

endmodule
`default_nettype wire

// File: tb/tb_rx_lbuf_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_rx_lbuf_sel
// Desc   : Scenario bench for rx_lbuf_sel; every dn pulse is matched against a
//          queue of expected returns (buffer id, final address, final room).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rx_lbuf_sel;

    localparam int c_TMO = 100;

    typedef struct {
        logic        id;
        logic [63:0] addr;
        logic [15:0] room;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t m_e;

    rx_lbuf_sel_if bus();

    rx_lbuf_sel #(
        .LBUF_QW     (16384),
        .TIMEOUT_CYC (c_TMO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [63:0] addr, input logic [15:0] room);
        exp_t e;
        e.id   = id;
        e.addr = addr;
        e.room = room;
        sb.push_back(e);
    endtask

    // Every returned buffer must match the oldest expected return.
    always @(negedge clk) begin
        if (!rst && (bus.lbuf1_dn || bus.lbuf2_dn)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dn_unexpected: got lbuf1_dn=%0b lbuf2_dn=%0b, required no dn",
                         bus.lbuf1_dn, bus.lbuf2_dn);
            end else begin
                m_e = sb.pop_front();
                if ({bus.lbuf2_dn, bus.lbuf1_dn} !== (m_e.id ? 2'b10 : 2'b01) ||
                    bus.wr_addr !== m_e.addr || bus.wr_room !== m_e.room ||
                    bus.wr_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL dn_return: got dn=%b addr=%h room=%0d vld=%b, required id=%0b addr=%h room=%0d vld=0",
                             {bus.lbuf2_dn, bus.lbuf1_dn}, bus.wr_addr, bus.wr_room,
                             bus.wr_vld, m_e.id, m_e.addr, m_e.room);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.wr_vld, bus.wr_id, bus.lbuf1_dn, bus.lbuf2_dn} !== 4'b0000 ||
            bus.wr_addr !== 64'd0 || bus.wr_room !== 16'd16384) begin
            errors++;
            $display("FAIL reset_state: got vld=%b id=%b dn=%b%b addr=%h room=%0d, required 0 0 00 0 16384",
                     bus.wr_vld, bus.wr_id, bus.lbuf2_dn, bus.lbuf1_dn, bus.wr_addr, bus.wr_room);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_open1();
        bus.lbuf1_addr = 64'h1_0000_0000;
        bus.lbuf1_en   = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b1 || bus.wr_id !== 1'b0 ||
            bus.wr_addr !== 64'h1_0000_0000 || bus.wr_room !== 16'd16384) begin
            errors++;
            $display("FAIL open1: got vld=%b id=%b addr=%h room=%0d, required 1 0 100000000 16384",
                     bus.wr_vld, bus.wr_id, bus.wr_addr, bus.wr_room);
        end
    endtask

    task automatic test_fill();
        push(1'b0, 64'h1_0002_0000, 16'd0);
        for (int i = 0; i < 64; i++) begin
            bus.adv_vld = 1'b1;
            bus.adv_qw  = 9'd256;
            tick();
            if (i == 0 || i == 62) begin
                @(negedge clk);
                checks++;
                if (bus.wr_room !== 16'(16384 - 256 * (i + 1)) ||
                    bus.wr_addr !== 64'h1_0000_0000 + 64'(2048 * (i + 1))) begin
                    errors++;
                    $display("FAIL fill_step%0d: got room=%0d addr=%h, required room=%0d",
                             i, bus.wr_room, bus.wr_addr, 16384 - 256 * (i + 1));
                end
            end
        end
        bus.adv_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.lbuf1_dn !== 1'b1 || bus.wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL fill_close: got dn1=%b vld=%b, required dn1=1 vld=0",
                     bus.lbuf1_dn, bus.wr_vld);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.lbuf1_dn !== 1'b0) begin
            errors++;
            $display("FAIL fill_pulse_width: got dn1=%b one cycle later, required 0", bus.lbuf1_dn);
        end
    endtask

    task automatic test_stale_en();
        // lbuf1_en is still high from the previous buffer
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL stale_wait2: got vld=%b with lbuf2 idle, required 0", bus.wr_vld);
        end
        bus.lbuf2_addr = 64'hFFFF_FFFF_FFFF_FF00;
        bus.lbuf2_en   = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b1 || bus.wr_id !== 1'b1 || bus.wr_addr !== 64'hFFFF_FFFF_FFFF_FF00) begin
            errors++;
            $display("FAIL open2: got vld=%b id=%b addr=%h, required 1 1 ffffffffffffff00",
                     bus.wr_vld, bus.wr_id, bus.wr_addr);
        end
        bus.adv_vld = 1'b1;
        bus.adv_qw  = 9'd40;
        tick();
        bus.adv_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_addr !== 64'h40 || bus.wr_room !== 16'd16344) begin
            errors++;
            $display("FAIL addr_wrap: got addr=%h room=%0d, required 40 16344", bus.wr_addr, bus.wr_room);
        end
        push(1'b1, 64'h40, 16'd16344);
        bus.close = 1'b1;
        tick();
        bus.close    = 1'b0;
        bus.lbuf2_en = 1'b0;
        tick();
        // lbuf2 is re-armed but must be ignored in WAIT1; lbuf1 is stale
        bus.lbuf2_en = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL stale_wait1: got vld=%b with stale lbuf1_en, required 0", bus.wr_vld);
        end
        bus.lbuf2_en = 1'b0;
        bus.lbuf1_en = 1'b0;
        tick();
        bus.lbuf1_addr = 64'h2000;
        bus.lbuf1_en   = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b1 || bus.wr_id !== 1'b0 || bus.wr_addr !== 64'h2000 ||
            bus.wr_room !== 16'd16384) begin
            errors++;
            $display("FAIL reopen1: got vld=%b id=%b addr=%h room=%0d, required 1 0 2000 16384",
                     bus.wr_vld, bus.wr_id, bus.wr_addr, bus.wr_room);
        end
    endtask

    task automatic test_adv_close();
        bus.adv_vld = 1'b1;
        bus.adv_qw  = 9'd100;
        tick();
        bus.adv_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_room !== 16'd16284 || bus.wr_addr !== 64'h2320) begin
            errors++;
            $display("FAIL adv100: got room=%0d addr=%h, required 16284 2320", bus.wr_room, bus.wr_addr);
        end
        push(1'b0, 64'h2370, 16'd16274);
        bus.adv_vld = 1'b1;
        bus.adv_qw  = 9'd10;
        bus.close   = 1'b1;
        tick();
        bus.adv_vld = 1'b0;
        bus.close   = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.lbuf1_dn !== 1'b1) begin
            errors++;
            $display("FAIL adv_close_dn: got dn1=%b, required 1", bus.lbuf1_dn);
        end
        bus.lbuf1_en = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.lbuf1_dn !== 1'b0 || bus.lbuf2_dn !== 1'b0) begin
            errors++;
            $display("FAIL adv_close_single: got dn=%b%b, required 00", bus.lbuf2_dn, bus.lbuf1_dn);
        end
    endtask

    task automatic test_ignored();
        bus.adv_vld = 1'b1;
        bus.adv_qw  = 9'd50;
        bus.close   = 1'b1;
        repeat (2) tick();
        bus.adv_vld = 1'b0;
        bus.close   = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b0 || bus.wr_room !== 16'd16274) begin
            errors++;
            $display("FAIL idle_ignore: got vld=%b room=%0d, required 0 16274", bus.wr_vld, bus.wr_room);
        end
        bus.lbuf2_addr = 64'h5000;
        bus.lbuf2_en   = 1'b1;
        tick();
        push(1'b1, 64'h5000, 16'd16384);
        bus.close = 1'b1;
        tick();
        bus.close    = 1'b0;
        bus.lbuf2_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.lbuf2_dn !== 1'b1) begin
            errors++;
            $display("FAIL empty_close: got dn2=%b, required 1", bus.lbuf2_dn);
        end
    endtask

    task automatic test_reset_mid_act();
        bus.lbuf1_addr = 64'h100;
        bus.lbuf1_en   = 1'b1;
        tick();
        push(1'b0, 64'h100, 16'd16384);
        bus.close = 1'b1;
        tick();
        bus.close    = 1'b0;
        bus.lbuf1_en = 1'b0;
        bus.lbuf2_addr = 64'h9000;
        bus.lbuf2_en   = 1'b1;
        tick();
        bus.adv_vld = 1'b1;
        bus.adv_qw  = 9'd250;
        repeat (2) tick();
        bus.adv_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_id !== 1'b1 || bus.wr_room !== 16'd15884) begin
            errors++;
            $display("FAIL act2_500: got id=%b room=%0d, required 1 15884", bus.wr_id, bus.wr_room);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.wr_vld, bus.wr_id, bus.lbuf1_dn, bus.lbuf2_dn} !== 4'b0000 ||
            bus.wr_addr !== 64'd0 || bus.wr_room !== 16'd16384) begin
            errors++;
            $display("FAIL async_reset: got vld=%b id=%b dn=%b%b addr=%h room=%0d, required 0 0 00 0 16384",
                     bus.wr_vld, bus.wr_id, bus.lbuf2_dn, bus.lbuf1_dn, bus.wr_addr, bus.wr_room);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.lbuf2_dn !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_dn: got dn2=%b, required 0", bus.lbuf2_dn);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait1: got vld=%b with stale lbuf2_en, required 0", bus.wr_vld);
        end
        bus.lbuf2_en   = 1'b0;
        bus.lbuf1_addr = 64'hABC0;
        bus.lbuf1_en   = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.wr_vld !== 1'b1 || bus.wr_id !== 1'b0 || bus.wr_addr !== 64'hABC0) begin
            errors++;
            $display("FAIL recover: got vld=%b id=%b addr=%h, required 1 0 abc0",
                     bus.wr_vld, bus.wr_id, bus.wr_addr);
        end
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        seen = 1'b0;
        k    = 0;
`ifdef RX_LBUF_TIMEOUT_EN
        push(1'b0, 64'hABC8, 16'd16383);
`endif
        bus.adv_vld = 1'b1;
        bus.adv_qw  = 9'd1;
        tick();
        bus.adv_vld = 1'b0;
        while (!seen && k < 300) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (bus.lbuf1_dn === 1'b1) seen = 1'b1;
        end
        checks++;
`ifdef RX_LBUF_TIMEOUT_EN
        if (!seen || k != c_TMO) begin
            errors++;
            $display("FAIL timeout: got dn seen=%0b after %0d cycles, required dn after %0d", seen, k, c_TMO);
        end
`else
        if (seen || bus.wr_vld !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: got dn seen=%0b vld=%b after %0d idle cycles, required no dn and vld=1",
                     seen, bus.wr_vld, k);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.lbuf1_addr = 64'd0;
        bus.lbuf2_addr = 64'd0;
        bus.lbuf1_en   = 1'b0;
        bus.lbuf2_en   = 1'b0;
        bus.adv_vld    = 1'b0;
        bus.adv_qw     = 9'd0;
        bus.close      = 1'b0;

        test_reset();
        test_open1();
        test_fill();
        test_stale_en();
        test_adv_close();
        test_ignored();
        test_reset_mid_act();
        test_timeout();

        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending returns, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
